// File: rtl/spc_stack_if.sv
// spc_stack_if: command/status bundle for spc_stack; master drives commands, slave returns stack state.
interface spc_stack_if #(
  parameter int WIDTH      = 19,
  parameter int DEPTH_LOG2 = 5
);
  logic                  PUSH;
  logic                  POP;
  logic                  CLR_ERR;
  logic [WIDTH-1:0]      DI;
  logic [WIDTH-1:0]      DO;
  logic [DEPTH_LOG2-1:0] SP;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  EMPTY;
  logic                  FULL;
  logic                  OVF;
  logic                  UNF;
  modport master (output PUSH, POP, CLR_ERR, DI, input DO, SP, COUNT, EMPTY, FULL, OVF, UNF);
  modport slave  (input PUSH, POP, CLR_ERR, DI, output DO, SP, COUNT, EMPTY, FULL, OVF, UNF);
endinterface

// File: rtl/spc_stack.sv
// spc_stack: subroutine-PC stack with registered top-of-stack, occupancy and sticky OVF/UNF flags.
// Define SPC_STACK_WRAP_EN for the circular (CADR-compatible) pointer instead of saturating boundaries.
module spc_stack #(
  parameter int WIDTH      = 19,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic     CLK,
  input  logic     RESET,
  spc_stack_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SPC_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] sp_q, sp_d, wr_addr;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      do_q, do_d, rd_data;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push_op, pop_op, rep_op, empty, full;
  logic                  do_push, do_pop, do_rep, wr;
  always_comb begin
    push_op = bus.PUSH & ~bus.POP;
    pop_op  = bus.POP & ~bus.PUSH;
    rep_op  = bus.PUSH & bus.POP;
    empty   = count_q == '0;
    full    = count_q == {1'b1, {DEPTH_LOG2{1'b0}}};
    // saturating mode turns a replace on an empty stack into a push
    do_push = (push_op & (WRAP | ~full)) | (rep_op & empty & ~WRAP);
    do_pop  = pop_op & (WRAP | ~empty);
    do_rep  = rep_op & (WRAP | ~empty);
    wr      = do_push | do_rep;
    wr_addr = do_push ? sp_q + 1'b1 : sp_q;
    sp_d    = do_push ? sp_q + 1'b1 : do_pop ? sp_q - 1'b1 : sp_q;
    count_d = (do_push & ~full) ? count_q + 1'b1 : (do_pop & ~empty) ? count_q - 1'b1 : count_q;
    rd_data = mem_q[sp_q - 1'b1];
    do_d    = wr ? bus.DI : do_pop ? ((count_d == '0 && !WRAP) ? '0 : rd_data) : do_q;
    ovf_d   = (push_op & full) | (ovf_q & ~bus.CLR_ERR);
    unf_d   = (pop_op & empty) | (unf_q & ~bus.CLR_ERR);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp_q    <= '1;
      count_q <= '0;
      do_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      do_q    <= do_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (wr && !RESET) mem_q[wr_addr] <= bus.DI;
  end
  assign bus.DO    = do_q;
  assign bus.SP    = sp_q;
  assign bus.COUNT = count_q;
  assign bus.EMPTY = empty;
  assign bus.FULL  = full;
  assign bus.OVF   = ovf_q;
  assign bus.UNF   = unf_q;
endmodule

// File: tb/tb_spc_stack.sv
// tb_spc_stack: directed plus random stimulus against a queue-based stack model.
module tb_spc_stack;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [18:0] q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  spc_stack_if #(.WIDTH(19), .DEPTH_LOG2(5)) bus ();
  spc_stack #(.WIDTH(19), .DEPTH_LOG2(5)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_chk(input string tag);
    int n;
    n = q.size();
    chk({tag, ".sp"}, {27'd0, bus.SP}, 32'((n + 31) % 32));
    chk({tag, ".count"}, {26'd0, bus.COUNT}, 32'(n));
    chk({tag, ".do"}, {13'd0, bus.DO}, n == 0 ? 32'd0 : {13'd0, q[n-1]});
    chk({tag, ".empty"}, {31'd0, bus.EMPTY}, 32'(n == 0));
    chk({tag, ".full"}, {31'd0, bus.FULL}, 32'(n == 32));
    chk({tag, ".ovf"}, {31'd0, bus.OVF}, {31'd0, m_ovf});
    chk({tag, ".unf"}, {31'd0, bus.UNF}, {31'd0, m_unf});
  endtask
  task automatic cycle(input logic p, input logic po, input logic [18:0] d, input logic c);
    logic oe, ue;
    bus.PUSH = p; bus.POP = po; bus.DI = d; bus.CLR_ERR = c;
    oe = 1'b0; ue = 1'b0;
    if (p && !po) begin
      if (q.size() == 32) oe = 1'b1; else q.push_back(d);
    end else if (po && !p) begin
      if (q.size() == 0) ue = 1'b1; else void'(q.pop_back());
    end else if (p && po) begin
      if (q.size() == 0) q.push_back(d); else q[q.size()-1] = d;
    end
    m_ovf = oe | (m_ovf & ~c);
    m_unf = ue | (m_unf & ~c);
    @(posedge CLK);
    #1;
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.CLR_ERR = 1'b0;
`ifndef SPC_STACK_WRAP_EN
    model_chk("model");
`endif
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
  endtask
  initial begin
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.DI = '0; bus.CLR_ERR = 1'b0;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 19'd0, 1'b0);
    chk("rst.sp", {27'd0, bus.SP}, 32'd31);
    chk("rst.count", {26'd0, bus.COUNT}, 32'd0);
    chk("rst.empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("rst.do", {13'd0, bus.DO}, 32'd0);
    chk("rst.flags", {30'd0, bus.OVF, bus.UNF}, 32'd0);
    cycle(1'b1, 1'b0, 19'o1001, 1'b0);
    cycle(1'b1, 1'b0, 19'o1002, 1'b0);
    cycle(1'b1, 1'b0, 19'o1003, 1'b0);
    chk("lifo.pop1", {13'd0, bus.DO}, 32'o1003);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    chk("lifo.pop2", {13'd0, bus.DO}, 32'o1002);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    chk("lifo.pop3", {13'd0, bus.DO}, 32'o1001);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    chk("lifo.sp", {27'd0, bus.SP}, 32'd31);
    chk("lifo.count", {26'd0, bus.COUNT}, 32'd0);
    chk("lifo.empty", {31'd0, bus.EMPTY}, 32'd1);
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 19'(i), 1'b0);
    chk("fill.full", {31'd0, bus.FULL}, 32'd1);
    cycle(1'b1, 1'b0, 19'o7777, 1'b0);
`ifdef SPC_STACK_WRAP_EN
    chk("wrap.sp", {27'd0, bus.SP}, 32'd0);
    chk("wrap.count", {26'd0, bus.COUNT}, 32'd32);
    chk("wrap.do", {13'd0, bus.DO}, 32'o7777);
    chk("wrap.ovf", {31'd0, bus.OVF}, 32'd1);
    chk("wrap.pop0", {13'd0, bus.DO}, 32'o7777);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    for (int i = 31; i >= 2; i--) begin
      chk("wrap.popn", {13'd0, bus.DO}, 32'(i));
      cycle(1'b0, 1'b1, 19'd0, 1'b0);
    end
`else
    chk("ovf.do", {13'd0, bus.DO}, 32'd31);
    chk("ovf.flag", {31'd0, bus.OVF}, 32'd1);
    chk("ovf.count", {26'd0, bus.COUNT}, 32'd32);
    cycle(1'b0, 1'b0, 19'd0, 1'b1);
    chk("ovf.clr", {31'd0, bus.OVF}, 32'd0);
`endif
    do_reset();
`ifndef SPC_STACK_WRAP_EN
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    chk("unf.flag", {31'd0, bus.UNF}, 32'd1);
    chk("unf.sp", {27'd0, bus.SP}, 32'd31);
    chk("unf.count", {26'd0, bus.COUNT}, 32'd0);
    cycle(1'b1, 1'b1, 19'o55, 1'b0);
    chk("repempty.count", {26'd0, bus.COUNT}, 32'd1);
    chk("repempty.do", {13'd0, bus.DO}, 32'o55);
    chk("repempty.ovf", {31'd0, bus.OVF}, 32'd0);
    cycle(1'b0, 1'b1, 19'd0, 1'b1);
    chk("unf.cleared", {31'd0, bus.UNF}, 32'd0);
    cycle(1'b1, 1'b0, 19'o11, 1'b0);
    cycle(1'b1, 1'b0, 19'o22, 1'b0);
    cycle(1'b1, 1'b1, 19'o33, 1'b0);
    chk("rep.do", {13'd0, bus.DO}, 32'o33);
    chk("rep.count", {26'd0, bus.COUNT}, 32'd2);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    chk("rep.after", {13'd0, bus.DO}, 32'o11);
    cycle(1'b0, 1'b1, 19'd0, 1'b0);
    cycle(1'b0, 1'b1, 19'd0, 1'b1);
    chk("unf.setwins", {31'd0, bus.UNF}, 32'd1);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic p, po;
      r = int'($urandom_range(0, 99));
      if (i < 300) begin
        p = r < 70; po = r >= 55;
      end else begin
        p = r < 30; po = r >= 15;
      end
      cycle(p, po, 19'($urandom), $urandom_range(0, 15) == 0);
    end
`endif
    cycle(1'b1, 1'b0, 19'o4242, 1'b0);
    cycle(1'b1, 1'b0, 19'o4343, 1'b0);
    #3 RESET = 1'b1;
    #1;
    chk("arst.sp", {27'd0, bus.SP}, 32'd31);
    chk("arst.count", {26'd0, bus.COUNT}, 32'd0);
    chk("arst.do", {13'd0, bus.DO}, 32'd0);
    chk("arst.empty", {30'd0, bus.EMPTY, bus.FULL}, 32'd2);
    chk("arst.flags", {30'd0, bus.OVF, bus.UNF}, 32'd0);
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    cycle(1'b0, 1'b0, 19'd0, 1'b0);
    chk("arst.idle", {26'd0, bus.COUNT}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
